dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 4 KB data memory between the CPU load/store port (port 0) and the motor-control
//  accelerator (PID/PWM coefficient and sample traffic, port 1). Exactly one access issues per cycle.
//  Port 0 wins by fixed priority, with anti-starvation for port 1 and bounded burst locking.
//  Sits between both requesters and dmem; read responses are registered with 1-cycle latency.
// PARAMETERS
//  MAX_WAIT   default 8   cycles port 1 may wait with valid high before it is forced to win (>=1)
//  MAX_LOCK   default 4   max consecutive locked beats a port may hold the grant (>=1)
//  ADDR_W     default 32  requester/memory address width
// PORTS
//  clk          in   1       single clock; all state updates on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  p0_valid     in   1       CPU request valid
//  p0_ready     out  1       CPU request accepted this cycle (combinational grant)
//  p0_addr      in   ADDR_W  CPU byte address
//  p0_we        in   1       1 = write, 0 = read
//  p0_wdata     in   32      CPU write data
//  p0_be        in   4       CPU byte enables (writes only)
//  p0_lock      in   1       hold grant for the next beat
//  p0_rsp_valid out  1       read data valid (1 cycle after accepted read)
//  p0_rdata     out  32      registered read data
//  p1_*         -    -       identical set for the accelerator port
//  mem_address  out  ADDR_W  to dmem address
//  mem_read     out  1       to dmem read enable
//  mem_wdata    out  32      to dmem write data
//  mem_byte_en  out  4       to dmem byte enables; 4'b0000 when not writing
//  mem_data     in   32      combinational read data from dmem
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=ARB, wait_cnt=0, lock_cnt=0, p*_rsp_valid=0, p*_rdata=0.
//    mem_read=0 and mem_byte_en=0 whenever no grant exists. No response is owed for a beat in flight at reset.
//  - Grant (combinational, one-hot or none):
//    - LOCK0 -> port 0 only.
//    - LOCK1 -> port 1 only.
//    - ARB -> port 1 if p1_valid && wait_cnt==MAX_WAIT; else port 0 if p0_valid; else port 1 if p1_valid.
//  - pX_ready = grantX. A beat is accepted when pX_valid && pX_ready. Requesters keep inputs stable until ready.
//  - Accepted read: mem_read=1 and mem_address=addr that cycle. pX_rdata<=mem_data and pX_rsp_valid=1 next
//    cycle, held for exactly 1 cycle. No response backpressure.
//  - Accepted write: mem_byte_en=be, mem_wdata=wdata, mem_read=0. The write commits at that posedge.
//    No response is generated. A be=0000 write is accepted and is a no-op.
//  - Address bits [1:0] are passed through unmodified. Alignment is the requester's duty.
//  - wait_cnt: saturating at MAX_WAIT; increments while p1_valid && !grant1; clears on a p1 accept or
//    when p1_valid is low.
//  - FSM (states ARB, LOCK0, LOCK1):
//    - ARB -> LOCKx on an accepted beat from port x with pX_lock=1 (lock_cnt<=1).
//    - LOCKx: each accepted beat with lock=1 increments lock_cnt.
//    - LOCKx -> ARB on an accepted beat with lock=0, OR when lock_cnt==MAX_LOCK after that beat,
//      OR when pX_valid drops while locked.
//    - A locked port's lock is ignored in the forced-exit cycle.
//  - Simultaneous events: lock beats port-1 starvation priority. Worst-case port 1 wait is
//    MAX_LOCK+MAX_WAIT cycles.
//  - Back-to-back reads from different ports in consecutive cycles each get their own rsp_valid.
// STRUCTURE
//  - Package dmem_arb_pkg:
//    - arb_state_e {ARB, LOCK0, LOCK1}
//    - PORT_CPU=0, PORT_ACC=1
//    - localparam function for the counter width, clog2(max+1)
//  - Sub-module dmem_arb_sat_cnt: saturating up-counter with inc/clr/max inputs and an at_max output.
//    Instanced twice (wait_cnt, lock_cnt).
// TESTING
//  1. Reset then p0 read 0x010 with mem[4]=0xDEADBEEF -> p0_ready same cycle; next cycle p0_rsp_valid=1,
//     p0_rdata=0xDEADBEEF; mem_byte_en=0.
//  2. p0 write 0x020, wdata=0x11223344, be=0101, then p1 read 0x020 -> mem_byte_en=0101 on the write
//     cycle; p1_rdata shows bytes 0,2 updated.
//  3. p0_valid held high continuously, p1_valid high from cycle 0, MAX_WAIT=8 -> p1 granted on exactly
//     cycle 8; wait_cnt returns to 0.
//  4. p1 burst of 6 beats with lock=1, MAX_LOCK=4, p0 waiting -> p1 gets 4 consecutive grants, then p0
//     is granted next; FSM returns to ARB.
//  5. Both valid, p1 starved (wait_cnt=MAX_WAIT) in the same cycle p0 is in LOCK0 -> p0 keeps the grant
//     until lock exit, then p1 wins.
//  6. rst_n pulsed low mid-cycle after an accepted read -> p0_rsp_valid=0 immediately, state=ARB;
//     no spurious response after reset release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_ACC = 1;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter; clear wins over increment, holds once count reaches max_val.
module dmem_arb_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] max_val,
  output logic         at_max
);

  logic [W-1:0] count;

  assign at_max = (count == max_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU (port 0) by fixed priority,
// accelerator (port 1) protected by a starvation timer, bounded lock bursts for either port.
//
// state | meaning
// ARB   | open arbitration: starved p1, then p0, then p1
// LOCK0 | port 0 holds the grant for its locked burst
// LOCK1 | port 1 holds the grant for its locked burst
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int MAX_LOCK = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_be,
  input  logic              p0_lock,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rdata,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_be,
  input  logic              p1_lock,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byte_en,
  input  logic [31:0]       mem_data
);

  localparam int WAIT_W = cnt_width(MAX_WAIT);
  localparam int LOCK_W = cnt_width(MAX_LOCK);

  arb_state_e state, state_nxt;
  logic [1:0] grant;
  logic       wait_at_max;
  logic       lock_last;
  logic       wait_inc, wait_clr;
  logic       lock_inc, lock_clr;
  logic       rd0, rd1;

  // Starvation timer for port 1
  assign wait_inc = p1_valid && !grant[PORT_ACC];
  assign wait_clr = !p1_valid || grant[PORT_ACC];

  dmem_arb_sat_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (wait_inc),
    .clr     (wait_clr),
    .max_val (WAIT_W'(MAX_WAIT)),
    .at_max  (wait_at_max)
  );

  // Counts beats already held; at_max means the current beat is the last one allowed
  assign lock_inc = (state_nxt != ARB);
  assign lock_clr = (state_nxt == ARB);

  dmem_arb_sat_cnt #(.W(LOCK_W)) u_lock_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (lock_inc),
    .clr     (lock_clr),
    .max_val (LOCK_W'(MAX_LOCK - 1)),
    .at_max  (lock_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB: begin
        if (!lock_last) begin
          if (grant[PORT_CPU] && p0_lock) begin
            state_nxt = LOCK0;
          end else if (grant[PORT_ACC] && p1_lock) begin
            state_nxt = LOCK1;
          end
        end
      end
      LOCK0: begin
        if (!(grant[PORT_CPU] && p0_lock) || lock_last) begin
          state_nxt = ARB;
        end
      end
      LOCK1: begin
        if (!(grant[PORT_ACC] && p1_lock) || lock_last) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Grant only ever goes to a valid requester, so grant equals accept
  always_comb begin
    grant = 2'b00;
    unique case (state)
      LOCK0: grant[PORT_CPU] = p0_valid;
      LOCK1: grant[PORT_ACC] = p1_valid;
      default: begin
        if (p1_valid && wait_at_max) begin
          grant[PORT_ACC] = 1'b1;
        end else if (p0_valid) begin
          grant[PORT_CPU] = 1'b1;
        end else if (p1_valid) begin
          grant[PORT_ACC] = 1'b1;
        end
      end
    endcase
  end

  assign p0_ready = grant[PORT_CPU];
  assign p1_ready = grant[PORT_ACC];

  always_comb begin
    mem_address = '0;
    mem_read    = 1'b0;
    mem_wdata   = '0;
    mem_byte_en = 4'b0000;
    if (grant[PORT_CPU]) begin
      mem_address = p0_addr;
      mem_read    = !p0_we;
      mem_wdata   = p0_wdata;
      mem_byte_en = p0_we ? p0_be : 4'b0000;
    end else if (grant[PORT_ACC]) begin
      mem_address = p1_addr;
      mem_read    = !p1_we;
      mem_wdata   = p1_wdata;
      mem_byte_en = p1_we ? p1_be : 4'b0000;
    end
  end

  assign rd0 = grant[PORT_CPU] && !p0_we;
  assign rd1 = grant[PORT_ACC] && !p1_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rsp_valid <= 1'b0;
      p0_rdata     <= '0;
      p1_rsp_valid <= 1'b0;
      p1_rdata     <= '0;
    end else begin
      p0_rsp_valid <= rd0;
      p1_rsp_valid <= rd1;
      if (rd0) begin
        p0_rdata <= mem_data;
      end
      if (rd1) begin
        p1_rdata <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus randomized traffic for dmem_arbiter, checked against a behavioural model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int MAX_LOCK = 4;
  localparam int ADDR_W   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              p0_valid, p0_ready, p0_we, p0_lock, p0_rsp_valid;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata, p0_rdata;
  logic [3:0]        p0_be;
  logic              p1_valid, p1_ready, p1_we, p1_lock, p1_rsp_valid;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata, p1_rdata;
  logic [3:0]        p1_be;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic [31:0]       mem_wdata, mem_data;
  logic [3:0]        mem_byte_en;

  logic [31:0] dmem   [0:1023];
  logic [31:0] shadow [0:1023];

  int tests = 0;
  int fails = 0;

  // reference model state
  int lock_owner = -1;
  int lock_beats = 0;
  int p1_wait    = 0;
  int last_g     = -1;
  int obs_g      = -1;

  always #5 clk = ~clk;

  assign mem_data = dmem[mem_address[11:2]];

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_valid     (p0_valid),
    .p0_ready     (p0_ready),
    .p0_addr      (p0_addr),
    .p0_we        (p0_we),
    .p0_wdata     (p0_wdata),
    .p0_be        (p0_be),
    .p0_lock      (p0_lock),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rdata     (p0_rdata),
    .p1_valid     (p1_valid),
    .p1_ready     (p1_ready),
    .p1_addr      (p1_addr),
    .p1_we        (p1_we),
    .p1_wdata     (p1_wdata),
    .p1_be        (p1_be),
    .p1_lock      (p1_lock),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rdata     (p1_rdata),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_wdata    (mem_wdata),
    .mem_byte_en  (mem_byte_en),
    .mem_data     (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input logic l);
    if (port == 0) begin
      p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = b; p0_lock = l;
    end else begin
      p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = b; p1_lock = l;
    end
  endtask

  task automatic rand_req(input int port);
    logic v, w, l;
    logic [31:0] a, d;
    logic [3:0] b;
    v = ($urandom_range(0, 9) < 7);
    w = 1'($urandom_range(0, 1));
    a = 32'($urandom_range(0, 15)) << 2;
    d = $urandom;
    b = 4'($urandom_range(0, 15));
    l = ($urandom_range(0, 2) == 0);
    set_req(port, v, w, a, d, b, l);
  endtask

  // Who should win this cycle, from the arbitration rules
  function automatic int model_grant();
    if (lock_owner == 0) return p0_valid ? 0 : -1;
    if (lock_owner == 1) return p1_valid ? 1 : -1;
    if (p1_valid && p1_wait >= MAX_WAIT) return 1;
    if (p0_valid) return 0;
    if (p1_valid) return 1;
    return -1;
  endfunction

  // One clock: check combinational outputs at negedge, commit memory at posedge, check responses after
  task automatic cycle();
    int g, idx;
    logic we, lk, erv0, erv1;
    logic [31:0] a, wd, erd;
    logic [3:0] be, wr_en;
    logic [9:0] wr_idx;
    logic [31:0] wr_data;
    @(negedge clk);
    g  = model_grant();
    we = (g == 0) ? p0_we   : p1_we;
    a  = (g == 0) ? p0_addr : p1_addr;
    wd = (g == 0) ? p0_wdata : p1_wdata;
    be = (g == 0) ? p0_be   : p1_be;
    lk = (g == 0) ? p0_lock : p1_lock;
    obs_g = p0_ready ? 0 : (p1_ready ? 1 : -1);
    chk("p0_ready", 32'(p0_ready), 32'(g == 0));
    chk("p1_ready", 32'(p1_ready), 32'(g == 1));
    chk("mem_read", 32'(mem_read), 32'(g >= 0 && !we));
    chk("mem_byte_en", 32'(mem_byte_en), (g >= 0 && we) ? 32'(be) : 32'd0);
    if (g >= 0) chk("mem_address", mem_address, a);
    if (g >= 0 && we) chk("mem_wdata", mem_wdata, wd);
    wr_en = mem_byte_en; wr_idx = mem_address[11:2]; wr_data = mem_wdata;

    idx  = int'(a[11:2]);
    erv0 = (g == 0) && !we;
    erv1 = (g == 1) && !we;
    erd  = shadow[idx];
    if (g >= 0 && we) begin
      for (int i = 0; i < 4; i++) if (be[i]) shadow[idx][i*8 +: 8] = wd[i*8 +: 8];
    end

    if (g == 1 || !p1_valid) p1_wait = 0;
    else if (p1_wait < MAX_WAIT) p1_wait++;
    if (lock_owner >= 0) begin
      if (g == lock_owner && lk) begin
        lock_beats++;
        if (lock_beats >= MAX_LOCK) lock_owner = -1;
      end else begin
        lock_owner = -1;
      end
    end else if (g >= 0 && lk) begin
      lock_beats = 1;
      if (lock_beats < MAX_LOCK) lock_owner = g;
    end
    last_g = g;

    @(posedge clk);
    for (int i = 0; i < 4; i++) if (wr_en[i]) dmem[wr_idx][i*8 +: 8] = wr_data[i*8 +: 8];
    #1;
    chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(erv0));
    chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(erv1));
    if (erv0) chk("p0_rdata", p0_rdata, erd);
    if (erv1) chk("p1_rdata", p1_rdata, erd);
  endtask

  initial begin
    int seq[$];
    int exp4[7];
    for (int i = 0; i < 1024; i++) begin
      dmem[i]   = $urandom;
      shadow[i] = dmem[i];
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
    chk("rst_p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_byte_en", 32'(mem_byte_en), 32'd0);
    rst_n = 1'b1;

    // 1: plain CPU read
    dmem[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
    set_req(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF, 1'b0);
    cycle();
    chk("t1_rsp_valid", 32'(p0_rsp_valid), 32'd1);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // 2: partial write then read back from the accelerator
    dmem[8] = 32'hAABBCCDD; shadow[8] = 32'hAABBCCDD;
    set_req(0, 1'b1, 1'b1, 32'h020, 32'h11223344, 4'b0101, 1'b0);
    @(negedge clk);
    chk("t2_byte_en", 32'(mem_byte_en), 32'h5);
    cycle();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h020, 32'h0, 4'h0, 1'b0);
    cycle();
    chk("t2_rdata", p1_rdata, 32'hAA22CC44);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cycle();

    // 3: starvation forces p1 through every MAX_WAIT+1 cycles
    seq.delete();
    set_req(0, 1'b1, 1'b0, 32'h000, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h004, 32'h0, 4'h0, 1'b0);
    for (int c = 0; c < 18; c++) begin
      cycle();
      if (obs_g == 1) seq.push_back(c);
    end
    chk("t3_count", 32'(seq.size()), 32'd2);
    if (seq.size() == 2) begin
      chk("t3_first", 32'(seq[0]), 32'd8);
      chk("t3_second", 32'(seq[1]), 32'd17);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cycle();

    // 4: p1 locked burst capped at MAX_LOCK beats while p0 waits
    seq.delete();
    exp4 = '{1, 1, 1, 1, 0, 1, 1};
    set_req(1, 1'b1, 1'b0, 32'h040, 32'h0, 4'h0, 1'b1);
    cycle(); seq.push_back(obs_g);
    set_req(0, 1'b1, 1'b0, 32'h044, 32'h0, 4'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cycle(); seq.push_back(obs_g);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cycle(); seq.push_back(obs_g);
    set_req(1, 1'b1, 1'b0, 32'h040, 32'h0, 4'h0, 1'b0);
    cycle(); seq.push_back(obs_g);
    for (int i = 0; i < 7; i++) chk($sformatf("t4_beat%0d", i), 32'(seq[i]), 32'(exp4[i]));
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cycle();

    // 5: p0 lock outranks a starved p1 until the lock runs out
    seq.delete();
    set_req(0, 1'b1, 1'b0, 32'h008, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h00C, 32'h0, 4'h0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      cycle(); seq.push_back(obs_g);
    end
    p0_lock = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle(); seq.push_back(obs_g);
    end
    for (int i = 0; i < 12; i++) chk($sformatf("t5_cycle%0d", i), 32'(seq[i]), (i == 11) ? 32'd1 : 32'd0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cycle();

    // 6: async reset in the middle of a response cycle
    set_req(1, 1'b1, 1'b0, 32'h020, 32'h0, 4'h0, 1'b1);
    cycle();
    chk("t6_rsp_before", 32'(p1_rsp_valid), 32'd1);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rsp_in_reset", 32'(p1_rsp_valid), 32'd0);
    chk("t6_rdata_in_reset", p1_rdata, 32'd0);
    lock_owner = -1; lock_beats = 0; p1_wait = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    chk("t6_no_spurious", 32'(p1_rsp_valid), 32'd0);
    set_req(0, 1'b1, 1'b0, 32'h004, 32'h0, 4'h0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h008, 32'h0, 4'h0, 1'b0);
    cycle();
    chk("t6_arb_after_reset", 32'(obs_g), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (last_g == 0 || !p0_valid) rand_req(0);
      if (last_g == 1 || !p1_valid) rand_req(1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
